// File: rtl/dc_frame_packer.sv
// dc_frame_packer: serialises DC frames and launch commands into a 32-bit FIFO; statistics counters exist only with `DC_PACKER_STATS_EN.
module dc_frame_packer #(
  parameter int DAC_CHANNEL = 24,
  parameter int FRAME_WORDS = 62
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic [FRAME_WORDS-1:0][31:0] i_dc_regs,
  input  logic [4:0]                   i_channel_sel,
  input  logic                         i_frame_req,
  input  logic [3:0][31:0]             i_launch_cmd,
  input  logic                         i_launch_req,
  input  logic                         i_fifo_full,
  output logic [31:0]                  o_fifo_data,
  output logic                         o_fifo_wr,
  output logic                         o_busy,
  output logic                         o_frame_done,
  output logic                         o_launch_done,
  output logic                         o_err,
  output logic [15:0]                  o_frame_cnt,
  output logic [15:0]                  o_launch_cnt
);
  typedef enum logic [2:0] {IDLE, SEND_HDR, SEND_PAYLOAD, SEND_MARK, SEND_LAUNCH} state_t;
  localparam logic [5:0] NCH = 6'(DAC_CHANNEL);
  localparam logic [5:0] LAST = 6'(FRAME_WORDS - 1);
  state_t state, state_nxt;
  logic [FRAME_WORDS-1:0][31:0] frame_buf;
  logic [3:0][31:0] launch_buf;
  logic [4:0] ch;
  logic [5:0] idx;
  logic [1:0] lidx;
  logic [23:0] ch_mask;
  logic launch_go, frame_go, frame_bad, last_word, last_launch;
  logic unused;
  // only the low byte of word0 reaches the header
  assign unused = ^frame_buf[0][31:8];
  assign launch_go = state == IDLE && i_launch_req;
  assign frame_go = state == IDLE && !i_launch_req && i_frame_req && {1'b0, i_channel_sel} < NCH;
  assign frame_bad = state == IDLE && !i_launch_req && i_frame_req && {1'b0, i_channel_sel} >= NCH;
  assign last_word = state == SEND_PAYLOAD && idx == LAST;
  assign last_launch = state == SEND_LAUNCH && lidx == 2'd3;
  assign ch_mask = ~(24'd1 << ch);
  assign o_busy = state != IDLE;
  assign o_fifo_wr = o_busy && !i_fifo_full;

  always_comb begin
    state_nxt = state;
    o_fifo_data = state == SEND_HDR     ? {ch_mask, frame_buf[0][7:0]} :
                  state == SEND_PAYLOAD ? frame_buf[idx] :
                  state == SEND_MARK    ? 32'hFFFF_FFFF :
                  state == SEND_LAUNCH  ? launch_buf[lidx] : 32'd0;
    case (state)
      IDLE:         state_nxt = launch_go ? SEND_MARK : frame_go ? SEND_HDR : IDLE;
      SEND_HDR:     state_nxt = o_fifo_wr ? SEND_PAYLOAD : SEND_HDR;
      SEND_PAYLOAD: state_nxt = o_fifo_wr && last_word ? IDLE : SEND_PAYLOAD;
      SEND_MARK:    state_nxt = o_fifo_wr ? SEND_LAUNCH : SEND_MARK;
      SEND_LAUNCH:  state_nxt = o_fifo_wr && last_launch ? IDLE : SEND_LAUNCH;
      default:      state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) state <= IDLE;
    else state <= state_nxt;

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      frame_buf <= '0;
      launch_buf <= '0;
      ch <= '0;
      idx <= '0;
      lidx <= '0;
      o_frame_done <= 1'b0;
      o_launch_done <= 1'b0;
      o_err <= 1'b0;
    end else begin
      o_frame_done <= o_fifo_wr && last_word;
      o_launch_done <= o_fifo_wr && last_launch;
      o_err <= frame_bad;
      if (launch_go) launch_buf <= i_launch_cmd;
      if (frame_go) begin
        frame_buf <= i_dc_regs;
        ch <= i_channel_sel;
      end
      if (o_fifo_wr && state == SEND_HDR) idx <= 6'd1;
      else if (o_fifo_wr && state == SEND_PAYLOAD) idx <= idx + 6'd1;
      if (o_fifo_wr && state == SEND_MARK) lidx <= 2'd0;
      else if (o_fifo_wr && state == SEND_LAUNCH) lidx <= lidx + 2'd1;
    end

`ifdef DC_PACKER_STATS_EN
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      o_frame_cnt <= '0;
      o_launch_cnt <= '0;
    end else begin
      if (o_fifo_wr && last_word) o_frame_cnt <= o_frame_cnt + 16'd1;
      if (o_fifo_wr && last_launch) o_launch_cnt <= o_launch_cnt + 16'd1;
    end
`else
  assign o_frame_cnt = '0;
  assign o_launch_cnt = '0;
`endif
endmodule

// File: tb/tb_dc_frame_packer.sv
// tb_dc_frame_packer: randomized bench comparing the FIFO word stream against a queue-based model of frames and launches.
module tb_dc_frame_packer;
  localparam int FW = 62;
  localparam int NCH = 24;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [FW-1:0][31:0] dc_regs = '0;
  logic [4:0] channel_sel = '0;
  logic frame_req = 1'b0, launch_req = 1'b0, fifo_full = 1'b0;
  logic [3:0][31:0] launch_cmd = '0;
  logic [31:0] fifo_data;
  logic fifo_wr, busy, frame_done, launch_done, err;
  logic [15:0] frame_cnt, launch_cnt;
  int n_tests = 0, n_fail = 0;
  int n_fd = 0, n_ld = 0, n_err = 0;
  int fd0 = 0, ld0 = 0, er0 = 0;
  int m_frames = 0, m_launches = 0;
  bit rand_full = 1'b0;
  logic [31:0] obs[$];
  logic [31:0] exp_q[$];

  dc_frame_packer #(.DAC_CHANNEL(NCH), .FRAME_WORDS(FW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_dc_regs(dc_regs), .i_channel_sel(channel_sel),
    .i_frame_req(frame_req), .i_launch_cmd(launch_cmd), .i_launch_req(launch_req),
    .i_fifo_full(fifo_full), .o_fifo_data(fifo_data), .o_fifo_wr(fifo_wr), .o_busy(busy),
    .o_frame_done(frame_done), .o_launch_done(launch_done), .o_err(err),
    .o_frame_cnt(frame_cnt), .o_launch_cnt(launch_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (rst_n) begin
      if (fifo_wr) obs.push_back(fifo_data);
      if (frame_done) n_fd++;
      if (launch_done) n_ld++;
      if (err) n_err++;
    end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    fifo_full = rand_full ? ($urandom_range(0, 3) == 0) : fifo_full;
  endtask

  function automatic logic [31:0] hdr(input logic [4:0] c, input logic [31:0] w0);
    logic [31:0] h;
    h = 32'hFFFF_FF00 | {24'd0, w0[7:0]};
    h[8 + int'(c)] = 1'b0;
    return h;
  endfunction

  task automatic rand_regs();
    for (int i = 0; i < FW; i++) dc_regs[i] = $urandom;
    for (int i = 0; i < 4; i++) launch_cmd[i] = $urandom;
  endtask

  task automatic model_req(input bit f, input bit l, input logic [4:0] c);
    if (l) begin
      exp_q.push_back(32'hFFFF_FFFF);
      for (int i = 0; i < 4; i++) exp_q.push_back(launch_cmd[i]);
      m_launches++;
    end else if (f && int'(c) < NCH) begin
      exp_q.push_back(hdr(c, dc_regs[0]));
      for (int i = 1; i < FW; i++) exp_q.push_back(dc_regs[i]);
      m_frames++;
    end
  endtask

  task automatic start(input bit f, input bit l, input logic [4:0] c);
    fd0 = n_fd;
    ld0 = n_ld;
    er0 = n_err;
    channel_sel = c;
    frame_req = f;
    launch_req = l;
    model_req(f, l, c);
    tick();
    frame_req = 1'b0;
    launch_req = 1'b0;
  endtask

  task automatic compare_stream(input string tag);
    chk({tag, " len"}, 32'(obs.size()), 32'(exp_q.size()));
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++)
      chk($sformatf("%s w%0d", tag, i), obs[i], exp_q[i]);
    obs.delete();
    exp_q.delete();
  endtask

  task automatic finish(input string tag, input bit f, input bit l, input logic [4:0] c,
                        input bit noise, input int want_cyc);
    bit bad;
    int cyc;
    bad = f && !l && int'(c) >= NCH;
    cyc = 0;
    if (bad) chk({tag, " err"}, 32'(err), 32'd1);
    while (busy && cyc < 2000) begin
      if (noise) begin
        frame_req = 1'($urandom_range(0, 1));
        launch_req = 1'($urandom_range(0, 1));
        channel_sel = 5'($urandom);
      end
      tick();
      cyc++;
      frame_req = 1'b0;
      launch_req = 1'b0;
    end
    chk({tag, " timeout"}, 32'(busy), 32'd0);
    if (want_cyc >= 0) chk({tag, " cycles"}, 32'(cyc), 32'(want_cyc));
    tick();
    chk({tag, " frame_done"}, 32'(n_fd - fd0), 32'(f && !l && !bad));
    chk({tag, " launch_done"}, 32'(n_ld - ld0), 32'(l));
    chk({tag, " err pulses"}, 32'(n_err - er0), 32'(bad));
    compare_stream(tag);
  endtask

  task automatic txn(input string tag, input bit f, input bit l, input logic [4:0] c, input bit noise);
    int want;
    want = rand_full ? -1 : l ? 5 : (f && int'(c) < NCH) ? FW : 0;
    start(f, l, c);
    finish(tag, f, l, c, noise, want);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    m_frames = 0;
    m_launches = 0;
    obs.delete();
    exp_q.delete();
    tick();
  endtask

  task automatic chk_stats(input string tag);
`ifdef DC_PACKER_STATS_EN
    chk({tag, " frame_cnt"}, 32'(frame_cnt), 32'(m_frames % 65536));
    chk({tag, " launch_cnt"}, 32'(launch_cnt), 32'(m_launches % 65536));
`else
    chk({tag, " frame_cnt"}, 32'(frame_cnt), 32'd0);
    chk({tag, " launch_cnt"}, 32'(launch_cnt), 32'd0);
`endif
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst wr", 32'(fifo_wr), 32'd0);
    chk("rst data", fifo_data, 32'd0);
    chk("rst pulses", {29'd0, frame_done, launch_done, err}, 32'd0);
    chk("rst frame_cnt", 32'(frame_cnt), 32'd0);
    chk("rst launch_cnt", 32'(launch_cnt), 32'd0);
    rst_n = 1'b1;
    tick();

    rand_regs();
    dc_regs[0] = 32'h0000_00A5;
    start(1'b1, 1'b0, 5'd5);
    @(negedge clk);
    chk("hdr ch5 data", fifo_data, 32'hFFFF_DFA5);
    chk("hdr ch5 wr", 32'(fifo_wr), 32'd1);
    finish("frame ch5", 1'b1, 1'b0, 5'd5, 1'b0, FW);

    for (int i = 0; i < 4; i++) launch_cmd[i] = 32'(i + 1);
    txn("launch 1234", 1'b0, 1'b1, 5'd0, 1'b0);

    rand_regs();
    start(1'b1, 1'b0, 5'd7);
    repeat (10) tick();
    fifo_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall wr", 32'(fifo_wr), 32'd0);
      chk("stall data", fifo_data, dc_regs[10]);
      tick();
    end
    fifo_full = 1'b0;
    finish("stall frame", 1'b1, 1'b0, 5'd7, 1'b0, FW - 10);

    rand_regs();
    txn("both reqs", 1'b1, 1'b1, 5'd2, 1'b0);
    txn("ch24", 1'b1, 1'b0, 5'd24, 1'b0);
    txn("ch23", 1'b1, 1'b0, 5'd23, 1'b0);

    rand_regs();
    start(1'b1, 1'b0, 5'd3);
    repeat (30) tick();
    rst_n = 1'b0;
    #1;
    chk("midrst wr", 32'(fifo_wr), 32'd0);
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst data", fifo_data, 32'd0);
    while (exp_q.size() > 30) void'(exp_q.pop_back());
    tick();
    rst_n = 1'b1;
    tick();
    chk("midrst no done", 32'(n_fd - fd0), 32'd0);
    compare_stream("midrst partial");
    m_frames = 0;
    m_launches = 0;
    rand_regs();
    txn("after rst", 1'b1, 1'b0, 5'd0, 1'b0);

    do_reset();
    for (int k = 0; k < 3; k++) begin
      rand_regs();
      txn("stat frame", 1'b1, 1'b0, 5'($urandom_range(0, NCH - 1)), 1'b0);
    end
    for (int k = 0; k < 2; k++) begin
      rand_regs();
      txn("stat launch", 1'b0, 1'b1, 5'd0, 1'b0);
    end
    chk_stats("3f2l");

    rand_full = 1'b1;
    for (int k = 0; k < 30; k++) begin
      int kind;
      logic [4:0] c;
      kind = $urandom_range(0, 3);
      c = kind == 1 ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, NCH - 1));
      rand_regs();
      txn($sformatf("rnd%0d", k), kind != 2, kind >= 2, c, 1'b1);
    end
    rand_full = 1'b0;
    fifo_full = 1'b0;
    tick();
    chk_stats("random");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
